// File: rtl/uram_cam_ctrl.sv
// uram_cam_ctrl: key-search engine over one inferred UltraRAM array.
// Commands (FIND/ADD/DEL/CLEAR) arrive through a valid/ready handshake.
// The engine scans the array one address per cycle through a RD_LAT-deep
// registered read pipeline. It reports sticky ok/ko status, the matched
// index and the occupancy count.
module uram_cam_ctrl #(
    parameter int KEY_W  = 29,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic             find_ok,
    output logic             find_ko,
    output logic [IDX_W-1:0] match_idx,
    output logic [IDX_W:0]   count,
    output logic             full
);

    localparam int WORD_W = KEY_W + 1;
    localparam logic [1:0] OP_FIND = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_DEL  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_CLR, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [IDX_W:0]     cnt_q, cnt_d;        // init/clear write address or scan issue address
    logic               dup_q, dup_d;        // ADD: key already present
    logic               free_q, free_d;      // ADD: a free slot has been seen
    logic [IDX_W-1:0]   free_idx_q, free_idx_d;
    logic               res_ok_q, res_ok_d;  // outcome carried into the DONE cycle
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               find_ok_q, find_ok_d;
    logic               find_ko_q, find_ko_d;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic [IDX_W:0]     count_q, count_d;

    // Storage: {valid, key}; contents are never reset, INIT clears valid bits.
    (* ram_style = "ultra" *) logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0]  dat_pipe_q [RD_LAT];
    logic [IDX_W-1:0]   idx_pipe_q [RD_LAT];
    logic [RD_LAT-1:0]  vld_pipe_q;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]  mem_wdata;
    logic [IDX_W-1:0]   mem_raddr;
    logic               issue;

    logic               cmp_vld;
    logic [WORD_W-1:0]  cmp_word;
    logic [IDX_W-1:0]   cmp_idx;
    logic               cmp_hit;
    logic               cmp_last;
    logic               dup_n, free_n;
    logic [IDX_W-1:0]   free_idx_n;

    assign mem_raddr = cnt_q[IDX_W-1:0];
    assign issue     = (state_q == S_SCAN) && !cnt_q[IDX_W];

    // Memory write port plus registered read and its latency pipeline (no reset on data).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        dat_pipe_q[0] <= mem[mem_raddr];
        for (int k = 1; k < RD_LAT; k++) begin
            dat_pipe_q[k] <= dat_pipe_q[k-1];
        end
    end

    // Valid/index tags travelling alongside the read data; flushed outside SCAN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                idx_pipe_q[k] <= '0;
            end
        end else begin
            vld_pipe_q[0] <= issue;
            idx_pipe_q[0] <= mem_raddr;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1] && (state_q == S_SCAN);
                idx_pipe_q[k] <= idx_pipe_q[k-1];
            end
        end
    end

    assign cmp_vld    = vld_pipe_q[RD_LAT-1] && (state_q == S_SCAN);
    assign cmp_word   = dat_pipe_q[RD_LAT-1];
    assign cmp_idx    = idx_pipe_q[RD_LAT-1];
    assign cmp_hit    = cmp_word[KEY_W] && (cmp_word[KEY_W-1:0] == key_q);
    assign cmp_last   = (cmp_idx == IDX_W'(DEPTH - 1));
    assign dup_n      = dup_q | cmp_hit;
    assign free_n     = free_q | !cmp_word[KEY_W];
    assign free_idx_n = free_q ? free_idx_q : cmp_idx;

    // Control and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_INIT;
            op_q        <= OP_FIND;
            key_q       <= '0;
            cnt_q       <= '0;
            dup_q       <= 1'b0;
            free_q      <= 1'b0;
            free_idx_q  <= '0;
            res_ok_q    <= 1'b0;
            res_idx_q   <= '0;
            find_ok_q   <= 1'b0;
            find_ko_q   <= 1'b0;
            match_idx_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            dup_q       <= dup_d;
            free_q      <= free_d;
            free_idx_q  <= free_idx_d;
            res_ok_q    <= res_ok_d;
            res_idx_q   <= res_idx_d;
            find_ok_q   <= find_ok_d;
            find_ko_q   <= find_ko_d;
            match_idx_q <= match_idx_d;
            count_q     <= count_d;
        end
    end

    // Next-state, memory write port and status update logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        dup_d       = dup_q;
        free_d      = free_q;
        free_idx_d  = free_idx_q;
        res_ok_d    = res_ok_q;
        res_idx_d   = res_idx_q;
        find_ok_d   = find_ok_q;
        find_ko_d   = find_ko_q;
        match_idx_d = match_idx_q;
        count_d     = count_q;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q[IDX_W-1:0];
        mem_wdata   = '0;

        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    key_d     = cmd_key;
                    cnt_d     = '0;
                    dup_d     = 1'b0;
                    free_d    = 1'b0;
                    find_ok_d = 1'b0;
                    find_ko_d = 1'b0;
                    state_d   = (cmd_op == OP_CLR) ? S_CLR : S_SCAN;
                end
            end
            S_SCAN: begin
                if (!cnt_q[IDX_W]) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cmp_vld) begin
                    if (op_q == OP_ADD) begin
                        dup_d      = dup_n;
                        free_d     = free_n;
                        free_idx_d = free_idx_n;
                        if (cmp_last) begin
                            res_ok_d  = !dup_n && free_n;
                            res_idx_d = free_idx_n;
                            state_d   = S_DONE;
                        end
                    end else if (cmp_hit) begin
                        res_ok_d  = 1'b1;
                        res_idx_d = cmp_idx;
                        state_d   = S_DONE;
                    end else if (cmp_last) begin
                        res_ok_d = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CLR: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
                    res_ok_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                mem_waddr = res_idx_q;
                if (res_ok_q) begin
                    find_ok_d = 1'b1;
                    case (op_q)
                        OP_ADD: begin
                            mem_we      = 1'b1;
                            mem_wdata   = {1'b1, key_q};
                            match_idx_d = res_idx_q;
                            count_d     = count_q + 1'b1;
                        end
                        OP_DEL: begin
                            mem_we      = 1'b1;
                            match_idx_d = res_idx_q;
                            count_d     = count_q - 1'b1;
                        end
                        OP_CLR: begin
                            count_d = '0;
                        end
                        default: begin
                            match_idx_d = res_idx_q;
                        end
                    endcase
                end else begin
                    find_ko_d = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state_q == S_DONE);
    assign find_ok   = find_ok_q;
    assign find_ko   = find_ko_q;
    assign match_idx = match_idx_q;
    assign count     = count_q;
    assign full      = (count_q == (IDX_W + 1)'(DEPTH));

endmodule

// File: tb/tb_uram_cam_ctrl.sv
// Directed bench for uram_cam_ctrl with DEPTH=16, RD_LAT=2.
module tb_uram_cam_ctrl;

    localparam int KEY_W  = 29;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;
    localparam int IDX_W  = 4;

    localparam logic [1:0] OP_FIND = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_DEL  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [KEY_W-1:0] cmd_key = '0;
    logic             cmd_ready;
    logic             busy;
    logic             done;
    logic             find_ok;
    logic             find_ko;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W:0]   count;
    logic             full;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    uram_cam_ctrl #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_key  (cmd_key),
        .cmd_ready(cmd_ready),
        .busy     (busy),
        .done     (done),
        .find_ok  (find_ok),
        .find_ko  (find_ko),
        .match_idx(match_idx),
        .count    (count),
        .full     (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd1);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".find_ok"},   32'(find_ok),   32'd0);
        chk({tag, ".find_ko"},   32'(find_ko),   32'd0);
        chk({tag, ".match_idx"}, 32'(match_idx), 32'd0);
        chk({tag, ".count"},     32'(count),     32'd0);
        chk({tag, ".full"},      32'(full),      32'd0);
    endtask

    // Called at a negedge; releases reset and measures the INIT busy window.
    task automatic init_release(input string tag, input bit poke);
        int busy_n = 0;
        int done_n = 0;
        rstn = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (!busy) break;
            busy_n++;
            if (done) done_n++;
            if (poke && n == 3) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_ADD;
                cmd_key   = 29'h0555;
            end
            if (n == 5) cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'd16);
        chk({tag, ".init_done"},   32'(done_n), 32'd0);
        chk({tag, ".cmd_ready"},   32'(cmd_ready), 32'd1);
        chk({tag, ".count"},       32'(count), 32'd0);
        $display("INIT %s busy_cycles=%0d count=%0d", tag, busy_n, count);
    endtask

    // Called at a negedge with the DUT idle; issues one command and checks
    // completion latency plus the status at the cycle after done.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [KEY_W-1:0] key,
                           input int exp_lat, input bit exp_ok, input bit do_idx,
                           input int exp_idx, input int exp_cnt);
        int t0;
        int lat = -1;
        chk({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        t0        = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done),      32'd0);
        chk({tag, ".cmd_ready"},  32'(cmd_ready), 32'd1);
        chk({tag, ".find_ok"},    32'(find_ok),   32'(exp_ok));
        chk({tag, ".find_ko"},    32'(find_ko),   32'(!exp_ok));
        if (do_idx) chk({tag, ".match_idx"}, 32'(match_idx), 32'(exp_idx));
        chk({tag, ".count"},      32'(count),     32'(exp_cnt));
        chk({tag, ".full"},       32'(full),      32'(exp_cnt == DEPTH));
        $display("CMD %s op=%0d key=%0h lat=%0d ok=%0b ko=%0b idx=%0d count=%0d full=%0b",
                 tag, op, key, lat, find_ok, find_ko, match_idx, count, full);
    endtask

    initial begin
        int t0;

        // Reset held across several edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        $display("RESET values checked");

        // INIT with an ignored cmd_valid pulse.
        init_release("init1", 1'b1);

        // ADD then duplicate ADD.
        run_cmd("add_abc",     OP_ADD,  29'h0ABC, 19, 1'b1, 1'b1, 0, 1);
        run_cmd("add_abc_dup", OP_ADD,  29'h0ABC, 19, 1'b0, 1'b1, 0, 1);

        // FIND hit at index 0 and miss.
        run_cmd("find_abc",  OP_FIND, 29'h0ABC,  4, 1'b1, 1'b1, 0, 1);
        run_cmd("find_123",  OP_FIND, 29'h0123, 19, 1'b0, 1'b1, 0, 1);

        // Fill indices 1..15.
        for (int k = 1; k < DEPTH; k++) begin
            run_cmd($sformatf("fill%0d", k), OP_ADD, 29'(32'h100 + k), 19, 1'b1, 1'b1, k, k + 1);
        end

        // ADD into a full table.
        run_cmd("add_full",  OP_ADD,  29'h0999, 19, 1'b0, 1'b1, 15, 16);

        // DEL at index 5, then refill that slot.
        run_cmd("del_105",   OP_DEL,  29'h0105,  9, 1'b1, 1'b1, 5, 15);
        run_cmd("add_777",   OP_ADD,  29'h0777, 19, 1'b1, 1'b1, 5, 16);
        run_cmd("find_777",  OP_FIND, 29'h0777,  9, 1'b1, 1'b1, 5, 16);
        run_cmd("find_10f",  OP_FIND, 29'h010F, 19, 1'b1, 1'b1, 15, 16);
        run_cmd("del_miss",  OP_DEL,  29'h0555, 19, 1'b0, 1'b1, 15, 16);

        // CLEAR and a FIND of a previously stored key.
        run_cmd("clear",     OP_CLR,  29'h0000, 17, 1'b1, 1'b0, 0, 0);
        run_cmd("find_gone", OP_FIND, 29'h0ABC, 19, 1'b0, 1'b1, 15, 0);

        // Repopulate, then abort a FIND with reset.
        run_cmd("add_abc2",  OP_ADD,  29'h0ABC, 19, 1'b1, 1'b1, 0, 1);
        run_cmd("add_def",   OP_ADD,  29'h0DEF, 19, 1'b1, 1'b1, 1, 2);

        cmd_valid = 1'b1;
        cmd_op    = OP_FIND;
        cmd_key   = 29'h0BAD;
        t0        = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 0; n < 100 && cyc < t0 + 6; n++) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_reset_vals("abort");
        $display("ABORT reset asserted at T+%0d", cyc - t0);
        @(negedge clk);
        @(negedge clk);
        init_release("init2", 1'b0);

        run_cmd("find_abc_lost", OP_FIND, 29'h0ABC, 19, 1'b0, 1'b1, 0, 0);
        run_cmd("find_def_lost", OP_FIND, 29'h0DEF, 19, 1'b0, 1'b1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uram_cam_ctrl.md
# uram_cam_ctrl

Parametrised key-search engine over a single inferred UltraRAM array, replacing the fixed 29-bit single-command find controller behind the OCL status register. It accepts ADD/DEL/FIND/CLEAR commands through a valid/ready handshake and scans the array sequentially through a configurable read-latency pipeline. It reports sticky ok/ko status, the matched index and the occupancy count. The register-map layer in the CL top drives the command port and packs the status into its OCL read data.

## Interface
- KEY_W, 29: key width in bits.
- DEPTH, 256: number of entries; power of 2, at least 2.
- RD_LAT, 2: registered memory read latency in cycles, 1..4.
- IDX_W, $clog2(DEPTH): index width; derived, not overridden.

Ports:
- clk  in  1  clock (clk_main_a0 in the CL top).
- rstn  in  1  reset. Asynchronous, active-low, one clock.
- cmd_valid  in  1  command request.
- cmd_op  in  2  00 FIND, 01 ADD, 10 DEL, 11 CLEAR.
- cmd_key  in  KEY_W  key; ignored for CLEAR.
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  equals ~cmd_ready.
- done  out  1  one-cycle pulse at command completion.
- find_ok  out  1  sticky success of the last command.
- find_ko  out  1  sticky failure of the last command.
- match_idx  out  IDX_W  index that was found, written or deleted.
- count  out  IDX_W+1  number of valid entries.
- full  out  1  count == DEPTH.

## Operation
- Storage: DEPTH x (1 valid + KEY_W), inferred as ram_style "ultra". Contents are not reset.
- An entry matches when valid=1 and its key equals the latched key.
- States: INIT, IDLE, SCAN, CLR, DONE.
- INIT is the reset state. It writes valid=0 to addresses 0..DEPTH-1, one per cycle, then goes to IDLE. INIT produces no done pulse and leaves status unchanged.
- Accept: cmd_valid && cmd_ready. On accept, latch op and key, clear find_ok/find_ko, go to SCAN (or CLR for op 11).
- SCAN issues read address 0,1,2,... one per cycle and compares each returned word. In-flight reads after a terminating match are discarded.
- FIND: terminates on first match, giving ok with match_idx set. If all DEPTH entries are read with no match, result is ko.
- DEL: same scan as FIND. On match, write valid=0 at that index in the DONE cycle, give ok with match_idx, count decrements. No match gives ko.
- ADD: always scans all entries, tracking the lowest free index.
  - Duplicate present: ko.
  - Else free entry exists: write {1,key} at the lowest free index in the DONE cycle, give ok with match_idx set, count increments.
  - Else (full): ko.
- CLR: writes valid=0 to every address, then DONE with ok; count becomes 0.
- DONE lasts one cycle: done=1, status updated, next state IDLE.
- On ko, match_idx holds its previous value.
- cmd_valid while busy is ignored; it is not queued.

## Timing
- Reset values, applied immediately while rstn=0: cmd_ready=0, busy=1, done=0, find_ok=0, find_ko=0, match_idx=0, count=0, full=0.
- INIT: writes occur on the first DEPTH edges after rstn deasserts; cmd_ready=1 on the cycle after the last write.
- Cycle numbering: T is the accept cycle. Read address i is presented in cycle T+1+i, and its data is compared in cycle T+1+i+RD_LAT.
- Completion cycles (done=1):
  - FIND/DEL hit at index i: T+i+RD_LAT+2.
  - FIND/DEL miss: T+DEPTH+RD_LAT+1.
  - ADD, any outcome: T+DEPTH+RD_LAT+1.
  - CLEAR: T+DEPTH+1.
- cmd_ready rises in the cycle after done, so the earliest next accept is done+1.
- find_ok, find_ko, match_idx, count and full all update at the clock edge ending the DONE cycle. The status pair is one-hot or all-zero.
- Asserting rstn mid-operation aborts the command and re-enters INIT; any partial write is lost and no done pulse is produced.
- count never wraps: it stays at or below DEPTH and at or above 0 by construction.

## Test plan
All scenarios use DEPTH=16, RD_LAT=2.
- Release reset: busy=1 for exactly 16 cycles, then cmd_ready=1, count=0; a cmd_valid pulse during INIT is ignored.
- ADD 0x0ABC at T: done at T+19, find_ok=1, match_idx=0, count=1. Repeat ADD 0x0ABC: done at T'+19, find_ko=1, count=1.
- FIND 0x0ABC: done at T+4, find_ok=1, match_idx=0. FIND 0x0123: done at T+19, find_ko=1, match_idx still 0.
- ADD 16 distinct keys so full=1; a 17th ADD gives find_ko. DEL the key at index 5: done at T+9, ok, match_idx=5, count=15. Next ADD gives match_idx=5 and full=1.
- CLEAR: done at T+17, find_ok=1, count=0, full=0. FIND of a previously stored key then gives find_ko.
- Assert rstn=0 at T+6 of a FIND: all outputs immediately take reset values; after release, INIT runs 16 cycles and the earlier entries are gone (FIND gives ko).
